// File: rtl/voice_scheduler.sv
// Sample-period sequencer: time-multiplexes the shared voice datapath across enabled
// voices, then runs the filter and loads the output stage. Tracks overrun/timeout errors.
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned VIDX_W     = 2,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  dp_start,
  output logic [VIDX_W-1:0]     dp_voice,
  input  logic                  dp_done,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  flt_start,
  input  logic                  flt_done,
  output logic                  out_load,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout,
  input  logic                  err_clr
);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, ACC, FSTART, FWAIT, OUT} state_t;

  state_t                state, state_n;
  logic [NUM_VOICES-1:0] mask, mask_n, src;
  logic [VIDX_W-1:0]     idx, idx_n, found_idx;
  logic [7:0]            wcnt, wcnt_n;
  logic                  found, to_set, ov_set;

  // CLR searches the live enable mask from voice 0; ACC searches the latched mask above idx.
  assign src = (state == CLR) ? voice_en : mask;

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found && src[i] && (state == CLR || i > 32'(idx))) begin
        found     = 1'b1;
        found_idx = VIDX_W'(i);
      end
    end
  end

  assign ov_set = sample_tick && (state != IDLE);

  always_comb begin
    state_n = state;
    mask_n  = mask;
    idx_n   = idx;
    wcnt_n  = wcnt;
    to_set  = 1'b0;
    case (state)
      IDLE:   if (sample_tick) state_n = CLR;
      CLR: begin
        mask_n = voice_en;
        if (found) begin
          idx_n   = found_idx;
          state_n = START;
        end else begin
          state_n = FSTART;
        end
      end
      START: begin
        state_n = WAIT;
        wcnt_n  = '0;
      end
      WAIT: begin
        if (dp_done) begin
          state_n = ACC;
        end else if (wcnt == 8'(MAX_WAIT - 1)) begin
          to_set  = 1'b1;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      ACC: begin
        if (found) begin
          idx_n   = found_idx;
          state_n = START;
        end else begin
          state_n = FSTART;
        end
      end
      FSTART: begin
        state_n = FWAIT;
        wcnt_n  = '0;
      end
      FWAIT: begin
        if (flt_done) begin
          state_n = OUT;
        end else if (wcnt == 8'(MAX_WAIT - 1)) begin
          to_set  = 1'b1;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask      <= '0;
      idx       <= '0;
      wcnt      <= '0;
      dp_start  <= 1'b0;
      dp_voice  <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      flt_start <= 1'b0;
      out_load  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      idx       <= idx_n;
      wcnt      <= wcnt_n;
      dp_start  <= (state_n == START);
      dp_voice  <= idx_n;
      acc_clr   <= (state_n == CLR);
      acc_en    <= (state_n == ACC);
      flt_start <= (state_n == FSTART);
      out_load  <= (state_n == OUT);
      busy      <= (state_n != IDLE);
      overrun   <= ov_set | (overrun & ~err_clr);
      timeout   <= to_set | (timeout & ~err_clr);
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: per-cycle traces of two instances (default and
// MAX_WAIT=4) are recorded with a simple done-responder, then checked against hand timings.
module tb_voice_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, sample_tick, dp_done, flt_done, err_clr;
  logic [2:0] voice_en;

  logic       dp_start, acc_clr, acc_en, flt_start, out_load, busy, overrun, timeout;
  logic [1:0] dp_voice;
  logic       dp_start4, acc_clr4, acc_en4, flt_start4, out_load4, busy4, overrun4, timeout4;
  logic [1:0] dp_voice4;

  localparam int B_CLR = 9, B_ST = 8, B_ACC = 5, B_FST = 4, B_OUT = 3, B_BUSY = 2, B_OVR = 1, B_TO = 0;

  logic [9:0] tr  [0:39];
  logic [9:0] tr4 [0:39];
  int         last_n;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(3), .VIDX_W(2), .MAX_WAIT(255)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_en(voice_en),
    .dp_start(dp_start), .dp_voice(dp_voice), .dp_done(dp_done),
    .acc_clr(acc_clr), .acc_en(acc_en), .flt_start(flt_start), .flt_done(flt_done),
    .out_load(out_load), .busy(busy), .overrun(overrun), .timeout(timeout), .err_clr(err_clr)
  );

  voice_scheduler #(.NUM_VOICES(3), .VIDX_W(2), .MAX_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_en(voice_en),
    .dp_start(dp_start4), .dp_voice(dp_voice4), .dp_done(dp_done),
    .acc_clr(acc_clr4), .acc_en(acc_en4), .flt_start(flt_start4), .flt_done(flt_done),
    .out_load(out_load4), .busy(busy4), .overrun(overrun4), .timeout(timeout4), .err_clr(err_clr)
  );

  function automatic int first_hi(input int b, input bit use4);
    for (int k = 0; k < last_n; k++)
      if ((use4 ? tr4[k][b] : tr[k][b]) === 1'b1) return k;
    return -1;
  endfunction

  function automatic int cnt_hi(input int b, input bit use4);
    int c = 0;
    for (int k = 0; k < last_n; k++)
      if ((use4 ? tr4[k][b] : tr[k][b]) === 1'b1) c++;
    return c;
  endfunction

  // Cycle k = k-th sample after the run starts; the tick is high during cycle 0.
  // dly0/dly: cycles from dp_start to dp_done for voice 0 / other voices (0 = never).
  task automatic run_seq(input logic [2:0] en, input int dly0, input int dly, input int tick2,
                         input int clr_cyc, input int rst_cyc, input int en_cyc,
                         input logic [2:0] en2, input bit stray, input int ncyc);
    int dp_due = -1;
    int flt_due = -1;
    int d;
    voice_en = en; sample_tick = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
    dp_done = 1'b0; flt_done = 1'b0;
    last_n = ncyc;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      tr[k]  = {acc_clr, dp_start, dp_voice, acc_en, flt_start, out_load, busy, overrun, timeout};
      tr4[k] = {acc_clr4, dp_start4, dp_voice4, acc_en4, flt_start4, out_load4, busy4, overrun4, timeout4};
      if (tr[k][B_ST]) begin
        d = (tr[k][7:6] == 2'd0) ? dly0 : dly;
        dp_due = (d == 0) ? -1 : k + d;
      end
      if (tr[k][B_FST]) flt_due = k + 1;
      sample_tick = (k == 0) || (k == tick2);
      err_clr     = (k == clr_cyc);
      rst_n       = !(k == rst_cyc);
      if (k == en_cyc) voice_en = en2;
      dp_done  = (k == dp_due)  || (stray && (tr[k][B_ST] || tr[k][B_FST]));
      flt_done = (k == flt_due) || (stray && (tr[k][B_ST] || tr[k][B_FST]));
    end
    sample_tick = 1'b0; err_clr = 1'b0; rst_n = 1'b1; dp_done = 1'b0; flt_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sample_tick = 1'b0; dp_done = 1'b0; flt_done = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({acc_clr, dp_start, dp_voice, acc_en, flt_start, out_load, busy, overrun, timeout} !== 10'd0)
      $display("FAIL reset_outputs got %b want 0", {acc_clr, dp_start, dp_voice, acc_en, flt_start, out_load, busy, overrun, timeout});
    else passes++;
    checks++; if ({acc_clr4, dp_start4, dp_voice4, acc_en4, flt_start4, out_load4, busy4, overrun4, timeout4} !== 10'd0)
      $display("FAIL reset_outputs4 got %b want 0", {acc_clr4, dp_start4, dp_voice4, acc_en4, flt_start4, out_load4, busy4, overrun4, timeout4});
    else passes++;
  endtask

  task automatic test_nominal();
    do_reset();
    run_seq(3'b111, 1, 1, -1, -1, -1, -1, 3'b000, 1'b0, 20);
    checks++; if (first_hi(B_CLR, 0) !== 1) $display("FAIL nom_acc_clr got %0d want 1", first_hi(B_CLR, 0)); else passes++;
    checks++; if (cnt_hi(B_ST, 0) !== 3) $display("FAIL nom_start_cnt got %0d want 3", cnt_hi(B_ST, 0)); else passes++;
    checks++; if ({tr[2][B_ST], tr[2][7:6], tr[5][B_ST], tr[5][7:6], tr[8][B_ST], tr[8][7:6]} !== 9'b1_00_1_01_1_10)
      $display("FAIL nom_start_voice got %b want 100101110", {tr[2][B_ST], tr[2][7:6], tr[5][B_ST], tr[5][7:6], tr[8][B_ST], tr[8][7:6]});
    else passes++;
    checks++; if ({tr[3][7:6], tr[4][7:6], tr[9][7:6], tr[10][7:6]} !== 8'b00_00_10_10)
      $display("FAIL nom_voice_hold got %b want 00001010", {tr[3][7:6], tr[4][7:6], tr[9][7:6], tr[10][7:6]});
    else passes++;
    checks++; if ({tr[4][B_ACC], tr[7][B_ACC], tr[10][B_ACC]} !== 3'b111 || cnt_hi(B_ACC, 0) !== 3)
      $display("FAIL nom_acc_en got cnt %0d want 3 at 4/7/10", cnt_hi(B_ACC, 0));
    else passes++;
    checks++; if (first_hi(B_FST, 0) !== 11) $display("FAIL nom_flt_start got %0d want 11", first_hi(B_FST, 0)); else passes++;
    checks++; if (first_hi(B_OUT, 0) !== 13) $display("FAIL nom_out_load got %0d want 13", first_hi(B_OUT, 0)); else passes++;
    checks++; if (first_hi(B_BUSY, 0) !== 1 || cnt_hi(B_BUSY, 0) !== 13 || tr[14][B_BUSY] !== 1'b0)
      $display("FAIL nom_busy got first %0d cnt %0d want 1 13", first_hi(B_BUSY, 0), cnt_hi(B_BUSY, 0));
    else passes++;
  endtask

  task automatic test_masking();
    do_reset();
    run_seq(3'b101, 1, 1, -1, -1, -1, -1, 3'b000, 1'b0, 16);
    checks++; if ({tr[2][B_ST], tr[2][7:6], tr[5][B_ST], tr[5][7:6]} !== 6'b1_00_1_10 || cnt_hi(B_ST, 0) !== 2)
      $display("FAIL mask101_voices got %b cnt %0d want 100110 2", {tr[2][B_ST], tr[2][7:6], tr[5][B_ST], tr[5][7:6]}, cnt_hi(B_ST, 0));
    else passes++;
    checks++; if (first_hi(B_OUT, 0) !== 10) $display("FAIL mask101_out got %0d want 10", first_hi(B_OUT, 0)); else passes++;
    run_seq(3'b000, 1, 1, -1, -1, -1, -1, 3'b000, 1'b0, 10);
    checks++; if ({first_hi(B_CLR, 0), first_hi(B_FST, 0), first_hi(B_OUT, 0)} !== {32'sd1, 32'sd2, 32'sd4})
      $display("FAIL mask0_timing got %0d %0d %0d want 1 2 4", first_hi(B_CLR, 0), first_hi(B_FST, 0), first_hi(B_OUT, 0));
    else passes++;
    checks++; if (cnt_hi(B_ST, 0) !== 0) $display("FAIL mask0_no_start got %0d want 0", cnt_hi(B_ST, 0)); else passes++;
  endtask

  task automatic test_en_change();
    do_reset();
    run_seq(3'b111, 1, 1, -1, -1, -1, 3, 3'b001, 1'b0, 16);
    checks++; if (cnt_hi(B_ST, 0) !== 3 || first_hi(B_OUT, 0) !== 13)
      $display("FAIL enchg_same_period got cnt %0d out %0d want 3 13", cnt_hi(B_ST, 0), first_hi(B_OUT, 0));
    else passes++;
    run_seq(3'b001, 1, 1, -1, -1, -1, -1, 3'b000, 1'b0, 12);
    checks++; if (cnt_hi(B_ST, 0) !== 1 || first_hi(B_OUT, 0) !== 7)
      $display("FAIL enchg_next_period got cnt %0d out %0d want 1 7", cnt_hi(B_ST, 0), first_hi(B_OUT, 0));
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    run_seq(3'b111, 5, 1, -1, -1, -1, -1, 3'b000, 1'b0, 24);
    checks++; if (first_hi(B_ACC, 0) !== 7 + 1) $display("FAIL bp_first_acc got %0d want 8", first_hi(B_ACC, 0)); else passes++;
    checks++; if (first_hi(B_OUT, 0) !== 17) $display("FAIL bp_out_load got %0d want 17", first_hi(B_OUT, 0)); else passes++;
  endtask

  task automatic test_timeout();
    do_reset();
    run_seq(3'b001, 0, 0, -1, -1, -1, -1, 3'b000, 1'b0, 14);
    checks++; if ({tr4[6][B_BUSY], tr4[6][B_TO]} !== 2'b10) $display("FAIL to_last_wait got %b want 10", {tr4[6][B_BUSY], tr4[6][B_TO]}); else passes++;
    checks++; if ({tr4[7][B_BUSY], tr4[7][B_TO]} !== 2'b01) $display("FAIL to_expired got %b want 01", {tr4[7][B_BUSY], tr4[7][B_TO]}); else passes++;
    checks++; if (cnt_hi(B_OUT, 1) !== 0 || cnt_hi(B_ACC, 1) !== 0)
      $display("FAIL to_no_outputs got out %0d acc %0d want 0 0", cnt_hi(B_OUT, 1), cnt_hi(B_ACC, 1));
    else passes++;
    checks++; if (tr[13][B_TO] !== 1'b0) $display("FAIL to_default_inst got %b want 0", tr[13][B_TO]); else passes++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (timeout4 !== 1'b0) $display("FAIL to_err_clr got %b want 0", timeout4); else passes++;
    do_reset();
    run_seq(3'b001, 4, 4, -1, -1, -1, -1, 3'b000, 1'b0, 14);
    checks++; if (first_hi(B_OUT, 1) !== 10 || cnt_hi(B_TO, 1) !== 0)
      $display("FAIL to_done_on_expiry got out %0d to %0d want 10 0", first_hi(B_OUT, 1), cnt_hi(B_TO, 1));
    else passes++;
  endtask

  task automatic test_overrun();
    do_reset();
    run_seq(3'b111, 1, 1, 6, -1, -1, -1, 3'b000, 1'b0, 18);
    checks++; if ({tr[6][B_OVR], tr[7][B_OVR], tr[17][B_OVR]} !== 3'b011)
      $display("FAIL ovr_set got %b want 011", {tr[6][B_OVR], tr[7][B_OVR], tr[17][B_OVR]});
    else passes++;
    checks++; if (first_hi(B_OUT, 0) !== 13 || cnt_hi(B_OUT, 0) !== 1 || tr[14][B_BUSY] !== 1'b0)
      $display("FAIL ovr_seq_completes got out %0d cnt %0d want 13 1", first_hi(B_OUT, 0), cnt_hi(B_OUT, 0));
    else passes++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_err_clr got %b want 0", overrun); else passes++;
    run_seq(3'b111, 1, 1, 6, 6, -1, -1, 3'b000, 1'b0, 16);
    checks++; if (tr[7][B_OVR] !== 1'b1) $display("FAIL ovr_set_wins got %b want 1", tr[7][B_OVR]); else passes++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    run_seq(3'b111, 1, 1, 13, -1, -1, -1, 3'b000, 1'b0, 16);
    checks++; if ({tr[13][B_OVR], tr[14][B_OVR]} !== 2'b01) $display("FAIL ovr_out_cycle got %b want 01", {tr[13][B_OVR], tr[14][B_OVR]}); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_seq(3'b111, 1, 1, 4, -1, 6, -1, 3'b000, 1'b0, 12);
    checks++; if ({tr[6][B_ST], tr[6][7:6], tr[6][B_BUSY], tr[6][B_OVR]} !== 5'b0_01_1_1)
      $display("FAIL rstmid_before got %b want 00111", {tr[6][B_ST], tr[6][7:6], tr[6][B_BUSY], tr[6][B_OVR]});
    else passes++;
    checks++; if (tr[7] !== 10'd0 || tr4[7] !== 10'd0) $display("FAIL rstmid_cleared got %b %b want 0 0", tr[7], tr4[7]); else passes++;
    checks++; if (tr[11] !== 10'd0) $display("FAIL rstmid_stays_idle got %b want 0", tr[11]); else passes++;
    run_seq(3'b111, 1, 1, -1, -1, -1, -1, 3'b000, 1'b0, 16);
    checks++; if ({tr[2][B_ST], tr[2][7:6]} !== 3'b1_00 || first_hi(B_OUT, 0) !== 13)
      $display("FAIL rstmid_restart got %b out %0d want 100 13", {tr[2][B_ST], tr[2][7:6]}, first_hi(B_OUT, 0));
    else passes++;
  endtask

  task automatic test_stray();
    do_reset();
    dp_done = 1'b1; flt_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, acc_en, out_load} !== 3'b000) $display("FAIL stray_idle got %b want 000", {busy, acc_en, out_load}); else passes++;
    dp_done = 1'b0; flt_done = 1'b0;
    run_seq(3'b111, 1, 1, -1, -1, -1, -1, 3'b000, 1'b1, 18);
    checks++; if (first_hi(B_OUT, 0) !== 13 || cnt_hi(B_OUT, 0) !== 1 || cnt_hi(B_ACC, 0) !== 3 || first_hi(B_ACC, 0) !== 4)
      $display("FAIL stray_seq got out %0d/%0d acc %0d/%0d want 13/1 4/3",
               first_hi(B_OUT, 0), cnt_hi(B_OUT, 0), first_hi(B_ACC, 0), cnt_hi(B_ACC, 0));
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; dp_done = 1'b0; flt_done = 1'b0; err_clr = 1'b0;
    voice_en = 3'b000; last_n = 0;
    test_reset();
    test_nominal();
    test_masking();
    test_en_change();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_stray();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Top-level sequencer for the tt6581 synthesis datapath, instantiated inside tt_um_andreasp00. On each audio sample tick it time-multiplexes the single shared voice datapath (phase accumulator, waveform and envelope) across the enabled voices. It then triggers the shared filter and finally loads the output stage. It owns mix-accumulator clear/enable, error detection (tick overrun, handshake timeout) and the busy indication.

Parameters:
NUM_VOICES, 3, number of voices sharing the datapath (1..4)
VIDX_W, 2, width of voice index (ceil log2 NUM_VOICES, min 1)
MAX_WAIT, 255, cycles allowed in a wait state before timeout (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
sample_tick  in  1  one-cycle strobe, start of sample period
voice_en  in  NUM_VOICES  per-voice enable mask (bit i = voice i)
dp_start  out  1  one-cycle pulse: shared datapath computes voice dp_voice
dp_voice  out  VIDX_W  voice index for datapath; held stable from dp_start until the matching ACC cycle
dp_done  in  1  datapath result valid (one-cycle pulse)
acc_clr  out  1  clear mix accumulator
acc_en  out  1  add current voice result into mix accumulator
flt_start  out  1  one-cycle pulse: filter processes mix
flt_done  in  1  filter result valid
out_load  out  1  load filter result into output register/PWM
busy  out  1  high whenever FSM not IDLE
overrun  out  1  sticky: tick arrived while busy
timeout  out  1  sticky: wait state exceeded MAX_WAIT
err_clr  in  1  clears overrun and timeout

Behaviour:
- All outputs are Moore, decoded from registered state/regs. No combinational input-to-output paths.
- Reset (rst_n=0 at clk edge, any state, including mid-sequence): state=IDLE, voice idx=0, mask=0, wait counter=0. All outputs 0, both sticky flags 0.
- States: IDLE, CLR, START, WAIT, ACC, FSTART, FWAIT, OUT.
- IDLE: busy=0. If sample_tick, go to CLR.
- CLR: acc_clr=1. Latch voice_en into mask; it is held for the whole period, so later voice_en changes affect only the next period. If mask≠0: idx=lowest set bit, go to START. Else go to FSTART.
- START: dp_start=1, dp_voice=idx. Go to WAIT. dp_done in START is ignored.
- WAIT: on dp_done, go to ACC.
- ACC: acc_en=1. If a higher set mask bit exists, idx=next set bit, go to START. Else go to FSTART.
- FSTART: flt_start=1. Go to FWAIT. flt_done in FSTART is ignored.
- FWAIT: on flt_done, go to OUT.
- OUT: out_load=1. Go to IDLE.
- Latency: all voices enabled and done returned in the first WAIT/FWAIT cycle. Tick sampled at cycle 0 gives acc_clr @1, dp_start @2/5/8, acc_en @4/7/10, flt_start @11, out_load @13, busy high cycles 1..13, IDLE @14. Each extra responder wait cycle adds 1.
- Wait counter: 8-bit. Zeroed on entering WAIT/FWAIT, incremented each cycle in the state.
  - If counter==MAX_WAIT-1 and done is low: set timeout, go to IDLE, no acc_en/out_load.
  - done in the same cycle as expiry: done wins, no timeout.
- Overrun: sample_tick while state≠IDLE sets overrun. The tick is dropped and the current sequence continues. A tick in the OUT cycle is also an overrun.
- Sticky flags: a set event in the same cycle as err_clr leaves the flag set (set wins).
- dp_done/flt_done outside their wait states are ignored.

Test Plan:
- Nominal: voice_en=3'b111, responders assert done 1 cycle after start, tick @0 -> acc_clr @1; dp_start @2,5,8 with dp_voice 0,1,2; acc_en @4,7,10; flt_start @11; out_load @13; busy cycles 1..13.
- Masking: voice_en=3'b101 -> dp_voice sequence 0,2 only, out_load @10. voice_en=0 -> acc_clr @1, flt_start @2, out_load @4, no dp_start. voice_en changed mid-period -> no effect until the next tick.
- Back-pressure/timeout: dp_done delayed 5 cycles -> out_load shifted by +4 (nominal done arrives after 1 cycle). MAX_WAIT=4 with dp_done never asserted -> timeout=1 after 4 WAIT cycles, FSM IDLE, no out_load; err_clr -> timeout=0. done on expiry cycle -> no timeout.
- Overrun: second tick at cycle 6 of a sequence -> overrun=1, sequence completes normally with out_load @13. Tick with err_clr same cycle while busy -> overrun stays 1.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT of voice 1 -> next cycle all outputs 0, flags 0, state IDLE. A subsequent tick starts cleanly at voice 0.
- Stray handshakes: dp_done/flt_done pulses in IDLE/START/FSTART -> no state change, no extra acc_en/out_load.
